// File: rtl/mdio_mgmt_ctrl.sv
// Clause-22 MDIO master that shares one MDIO bus between a software command port
// and a periodic BMSR link-status poller, alternating grants when both are waiting.
module mdio_mgmt_ctrl #(
  parameter int         CLK_DIV       = 20,
  parameter int         POLL_EN       = 1,
  parameter int         POLL_INTERVAL = 1000000,
  parameter logic [4:0] POLL_PHY_ADDR = 5'd0
) (
  input  logic        clk_app_i,
  input  logic        rst_clk_app_n,
  input  logic        i_cmd_valid,
  output logic        o_cmd_ready,
  input  logic        i_cmd_write,
  input  logic [4:0]  i_phy_addr,
  input  logic [4:0]  i_reg_addr,
  input  logic [15:0] i_wdata,
  output logic        o_done,
  output logic [15:0] o_rdata,
  output logic        o_busy,
  output logic        o_link_up,
  output logic        o_mdc,
  output logic        o_mdo,
  output logic        o_mdo_oe,
  input  logic        i_mdi
);

  localparam int CW = $clog2(2 * CLK_DIV);
  localparam int TW = $clog2(POLL_INTERVAL + 1);
  localparam logic [CW-1:0] CNT_RISE = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(2 * CLK_DIV - 1);
  localparam logic [TW-1:0] TMR_LAST = TW'(POLL_INTERVAL - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] ph_cnt;
  logic [5:0]    bit_idx;
  logic [63:0]   frame_sr;
  logic [63:0]   load_frame;
  logic [15:0]   rx_sr;
  logic          is_read;
  logic          is_poll;
  logic          last_grant_cmd;
  logic          poll_pending;
  logic [TW-1:0] poll_tmr;
  logic          grant_cmd;
  logic          grant_poll;
  logic          bit_end;
  logic          frame_end;

  // A waiting poll blocks the command port only if the command port had the last turn.
  assign o_cmd_ready = (state == IDLE) && !(poll_pending && last_grant_cmd);
  assign grant_cmd   = i_cmd_valid && o_cmd_ready;
  assign grant_poll  = (state == IDLE) && poll_pending && !grant_cmd;
  assign bit_end     = (state == SHIFT) && (ph_cnt == CNT_LAST);
  assign frame_end   = bit_end && (bit_idx == 6'd63);
  assign o_busy      = (state != IDLE);
  assign o_mdo       = frame_sr[63];

  // Read frames carry ones in TA/DATA so the idle line level is shifted out there.
  always_comb begin
    load_frame = {32'hFFFF_FFFF, 2'b01, 2'b10, POLL_PHY_ADDR, 5'd1, 18'h3FFFF};
    if (grant_cmd) begin
      if (i_cmd_write)
        load_frame = {32'hFFFF_FFFF, 2'b01, 2'b01, i_phy_addr, i_reg_addr, 2'b10, i_wdata};
      else
        load_frame = {32'hFFFF_FFFF, 2'b01, 2'b10, i_phy_addr, i_reg_addr, 18'h3FFFF};
    end
  end

  always_ff @(posedge clk_app_i or negedge rst_clk_app_n) begin
    if (!rst_clk_app_n) state <= IDLE;
    else                state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (grant_cmd || grant_poll) state_nxt = SHIFT;
      SHIFT:   if (frame_end) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_app_i or negedge rst_clk_app_n) begin
    if (!rst_clk_app_n) begin
      ph_cnt         <= '0;
      bit_idx        <= '0;
      frame_sr       <= '1;
      rx_sr          <= '0;
      is_read        <= 1'b0;
      is_poll        <= 1'b0;
      last_grant_cmd <= 1'b0;
      o_mdc          <= 1'b0;
      o_mdo_oe       <= 1'b0;
      o_done         <= 1'b0;
      o_rdata        <= '0;
      o_link_up      <= 1'b0;
    end else begin
      o_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (grant_cmd || grant_poll) begin
            frame_sr       <= load_frame;
            is_read        <= grant_poll || !i_cmd_write;
            is_poll        <= grant_poll;
            last_grant_cmd <= grant_cmd;
            ph_cnt         <= '0;
            bit_idx        <= '0;
            o_mdc          <= 1'b0;
            o_mdo_oe       <= 1'b1;
          end
        end
        SHIFT: begin
          if (ph_cnt == CNT_RISE) begin
            o_mdc <= 1'b1;
            if (bit_idx >= 6'd48) rx_sr <= {rx_sr[14:0], i_mdi};
          end
          if (bit_end) begin
            o_mdc  <= 1'b0;
            ph_cnt <= '0;
            if (frame_end) begin
              frame_sr <= '1;
              o_mdo_oe <= 1'b0;
              o_done   <= !is_poll;
              if (is_poll)      o_link_up <= rx_sr[2];
              else if (is_read) o_rdata   <= rx_sr;
            end else begin
              bit_idx  <= bit_idx + 6'd1;
              frame_sr <= {frame_sr[62:0], 1'b1};
              // Release the line from the first turnaround bit onward on reads.
              o_mdo_oe <= !(is_read && bit_idx >= 6'd45);
            end
          end else begin
            ph_cnt <= ph_cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // A timer terminal in the same cycle as a poll grant re-arms the request.
  always_ff @(posedge clk_app_i or negedge rst_clk_app_n) begin
    if (!rst_clk_app_n) begin
      poll_tmr     <= '0;
      poll_pending <= 1'b0;
    end else if (POLL_EN != 0) begin
      poll_tmr <= (poll_tmr == TMR_LAST) ? '0 : poll_tmr + TW'(1);
      if (poll_tmr == TMR_LAST) poll_pending <= 1'b1;
      else if (grant_poll)      poll_pending <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mdio_mgmt_ctrl.sv
// Directed bench for mdio_mgmt_ctrl: a main instance with a behavioural PHY, a
// poll-saturated instance for grant alternation, and a poller-disabled instance.
module tb_mdio_mgmt_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a_n, rst_n;

  logic        valid_a, write_a, ready_a, done_a, busy_a, link_a, mdc_a, mdo_a, oe_a, mdi_a;
  logic [4:0]  phy_a, reg_a;
  logic [15:0] wdata_a, rdata_a;

  logic        valid_b, ready_b, done_b, busy_b, link_b, mdc_b, mdo_b, oe_b;
  logic        mdi_b = 1'b1;
  logic [15:0] rdata_b;

  logic        valid_c, ready_c, done_c, busy_c, link_c, mdc_c, mdo_c, oe_c;
  logic        mdi_c = 1'b1;
  logic [15:0] rdata_c;

  int checks = 0;
  int failures = 0;

  mdio_mgmt_ctrl #(.CLK_DIV(2), .POLL_EN(1), .POLL_INTERVAL(300), .POLL_PHY_ADDR(5'd3)) dut_a (
    .clk_app_i(clk), .rst_clk_app_n(rst_a_n), .i_cmd_valid(valid_a), .o_cmd_ready(ready_a),
    .i_cmd_write(write_a), .i_phy_addr(phy_a), .i_reg_addr(reg_a), .i_wdata(wdata_a),
    .o_done(done_a), .o_rdata(rdata_a), .o_busy(busy_a), .o_link_up(link_a),
    .o_mdc(mdc_a), .o_mdo(mdo_a), .o_mdo_oe(oe_a), .i_mdi(mdi_a));

  mdio_mgmt_ctrl #(.CLK_DIV(2), .POLL_EN(1), .POLL_INTERVAL(1), .POLL_PHY_ADDR(5'd3)) dut_b (
    .clk_app_i(clk), .rst_clk_app_n(rst_n), .i_cmd_valid(valid_b), .o_cmd_ready(ready_b),
    .i_cmd_write(1'b1), .i_phy_addr(5'd1), .i_reg_addr(5'd0), .i_wdata(16'h1234),
    .o_done(done_b), .o_rdata(rdata_b), .o_busy(busy_b), .o_link_up(link_b),
    .o_mdc(mdc_b), .o_mdo(mdo_b), .o_mdo_oe(oe_b), .i_mdi(mdi_b));

  mdio_mgmt_ctrl #(.CLK_DIV(2), .POLL_EN(0), .POLL_INTERVAL(300), .POLL_PHY_ADDR(5'd3)) dut_c (
    .clk_app_i(clk), .rst_clk_app_n(rst_n), .i_cmd_valid(valid_c), .o_cmd_ready(ready_c),
    .i_cmd_write(1'b1), .i_phy_addr(5'd1), .i_reg_addr(5'd0), .i_wdata(16'h5678),
    .o_done(done_c), .o_rdata(rdata_c), .o_busy(busy_c), .o_link_up(link_c),
    .o_mdc(mdc_c), .o_mdo(mdo_c), .o_mdo_oe(oe_c), .i_mdi(mdi_c));

  // PHY model for dut_a: decodes bits at MDC rise, answers reads after each MDC fall.
  logic [63:0] bits_a, oes_a, last_bits_a, last_oes_a;
  logic [15:0] bmsr = 16'h796D;
  logic [15:0] resp_a;
  logic        pm_mdc_a, pm_busy_a;
  int idx_a = 0, poll_cnt_a = 0, done_cnt_a = 0;

  always @(negedge clk) begin
    if (!rst_a_n) begin
      idx_a = 0;
      mdi_a = 1'b1;
      pm_mdc_a = 1'b0;
      pm_busy_a = 1'b0;
    end else begin
      if (busy_a && !pm_busy_a) begin
        idx_a = 0;
        bits_a = '0;
        oes_a = '0;
      end
      if (mdc_a && !pm_mdc_a && idx_a < 64) begin
        bits_a[63-idx_a] = mdo_a;
        oes_a[63-idx_a] = oe_a;
        idx_a++;
        if (idx_a == 64) begin
          last_bits_a = bits_a;
          last_oes_a = oes_a;
          if (bits_a[29:28] == 2'b10 && bits_a[27:23] == 5'd3 && bits_a[22:18] == 5'd1) poll_cnt_a++;
        end
      end
      if (!mdc_a && pm_mdc_a) begin
        resp_a = (bits_a[22:18] == 5'd1) ? bmsr : ((bits_a[22:18] == 5'd2) ? 16'h001C : 16'hFFFF);
        if (idx_a >= 47 && idx_a < 64 && bits_a[29:28] == 2'b10)
          mdi_a = (idx_a == 47) ? 1'b0 : resp_a[63-idx_a];
        else
          mdi_a = 1'b1;
      end
      if (done_a) done_cnt_a++;
      pm_mdc_a = mdc_a;
      pm_busy_a = busy_a;
    end
  end

  // Frame-type log for dut_b: a frame that ended with o_done was a command.
  logic log_b [8];
  logic pm_busy_b = 1'b0, seen_done_b = 1'b0;
  int nlog_b = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (done_b) seen_done_b = 1'b1;
      if (!busy_b && pm_busy_b) begin
        if (nlog_b < 8) log_b[nlog_b] = seen_done_b;
        nlog_b++;
        seen_done_b = 1'b0;
      end
      pm_busy_b = busy_b;
    end
  end

  // Ready-high cycles between a dut_c frame ending and the next starting.
  int gaps_c [4];
  int ngap_c = 0, gap_c = 0;
  logic counting_c = 1'b0, link_seen_c = 1'b0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (done_c) begin
        counting_c = 1'b1;
        gap_c = 0;
      end else if (counting_c) begin
        if (ready_c) gap_c++;
        if (busy_c) begin
          if (ngap_c < 4) gaps_c[ngap_c] = gap_c;
          ngap_c++;
          counting_c = 1'b0;
        end
      end
      if (link_c) link_seen_c = 1'b1;
    end
  end

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Presents one command to dut_a; returns just after the accepting clock edge.
  task automatic apply_stimulus(input string tag, input logic wr, input logic [4:0] phy,
                                input logic [4:0] ra, input logic [15:0] wd);
    int n;
    @(negedge clk);
    valid_a = 1'b1;
    write_a = wr;
    phy_a = phy;
    reg_a = ra;
    wdata_a = wd;
    n = 0;
    while (!ready_a && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check_output({tag, "_accept"}, 64'(ready_a), 64'(1));
    if (ready_a) @(posedge clk);
    #1 valid_a = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done_a && n < 3000);
    lat = n;
  endtask

  logic [63:0] exp64;
  logic [45:0] hdr;
  int lat, p, n, dc;

  initial begin
    rst_a_n = 1'b0;
    rst_n = 1'b0;
    valid_a = 1'b0;
    write_a = 1'b0;
    phy_a = '0;
    reg_a = '0;
    wdata_a = '0;
    valid_b = 1'b1;
    valid_c = 1'b1;
    repeat (3) @(negedge clk);

    check_output("rst_mdc", 64'(mdc_a), 64'(0));
    check_output("rst_mdo", 64'(mdo_a), 64'(1));
    check_output("rst_oe", 64'(oe_a), 64'(0));
    check_output("rst_done", 64'(done_a), 64'(0));
    check_output("rst_rdata", 64'(rdata_a), 64'(0));
    check_output("rst_busy", 64'(busy_a), 64'(0));
    check_output("rst_link", 64'(link_a), 64'(0));
    rst_a_n = 1'b1;
    rst_n = 1'b1;
    @(negedge clk);
    check_output("idle_ready", 64'(ready_a), 64'(1));

    $display("[TB] write phy=1 reg=0 data=1140");
    apply_stimulus("wr1", 1'b1, 5'd1, 5'd0, 16'h1140);
    wait_done(lat);
    check_output("wr1_latency", 64'(lat), 64'(257));
    @(negedge clk);
    check_output("wr1_done_width", 64'(done_a), 64'(0));
    exp64 = {32'hFFFF_FFFF, 2'b01, 2'b01, 5'd1, 5'd0, 2'b10, 16'h1140};
    check_output("wr1_bits", last_bits_a, exp64);
    check_output("wr1_oe", last_oes_a, 64'hFFFF_FFFF_FFFF_FFFF);
    check_output("idle_oe", 64'(oe_a), 64'(0));
    check_output("idle_mdc", 64'(mdc_a), 64'(0));

    $display("[TB] read phy=1 reg=2");
    apply_stimulus("rd1", 1'b0, 5'd1, 5'd2, 16'h0000);
    wait_done(lat);
    check_output("rd1_done", 64'(done_a), 64'(1));
    check_output("rd1_rdata", 64'(rdata_a), 64'(16'h001C));
    hdr = {32'hFFFF_FFFF, 2'b01, 2'b10, 5'd1, 5'd2};
    check_output("rd1_header", 64'(last_bits_a[63:18]), 64'(hdr));
    check_output("rd1_oe", last_oes_a, 64'hFFFF_FFFF_FFFC_0000);

    $display("[TB] read of absent register");
    apply_stimulus("rd2", 1'b0, 5'd7, 5'd3, 16'h0000);
    wait_done(lat);
    check_output("rd2_rdata", 64'(rdata_a), 64'(16'hFFFF));

    $display("[TB] link poll");
    #1 p = poll_cnt_a;
    n = 0;
    do begin @(negedge clk); #1; n++; end while (poll_cnt_a <= p && n < 2000);
    while (busy_a && n < 2000) begin @(negedge clk); n++; end
    check_output("poll1_seen", 64'(poll_cnt_a > p), 64'(1));
    check_output("link_up_796d", 64'(link_a), 64'(1));
    bmsr = 16'h7969;
    p = poll_cnt_a;
    n = 0;
    do begin @(negedge clk); #1; n++; end while (poll_cnt_a < p + 2 && n < 2000);
    while (busy_a && n < 2000) begin @(negedge clk); n++; end
    check_output("poll2_seen", 64'(poll_cnt_a >= p + 2), 64'(1));
    check_output("link_down_7969", 64'(link_a), 64'(0));
    check_output("rdata_hold_after_poll", 64'(rdata_a), 64'(16'hFFFF));

    $display("[TB] reset during read frame");
    apply_stimulus("rd3", 1'b0, 5'd1, 5'd2, 16'h0000);
    n = 0;
    do begin @(negedge clk); #1; n++; end while (idx_a < 20 && n < 2000);
    check_output("rd3_reached_bit20", 64'(idx_a), 64'(20));
    dc = done_cnt_a;
    #1 rst_a_n = 1'b0;
    #1;
    check_output("abort_mdc", 64'(mdc_a), 64'(0));
    check_output("abort_mdo", 64'(mdo_a), 64'(1));
    check_output("abort_oe", 64'(oe_a), 64'(0));
    check_output("abort_busy", 64'(busy_a), 64'(0));
    check_output("abort_done", 64'(done_a), 64'(0));
    check_output("abort_rdata", 64'(rdata_a), 64'(0));
    check_output("abort_link", 64'(link_a), 64'(0));
    repeat (3) @(negedge clk);
    rst_a_n = 1'b1;
    repeat (100) @(negedge clk);
    #1 check_output("abort_no_done", 64'(done_cnt_a), 64'(dc));

    $display("[TB] write after reset");
    apply_stimulus("wr2", 1'b1, 5'd2, 5'd4, 16'hA5C3);
    wait_done(lat);
    check_output("wr2_done", 64'(done_a), 64'(1));
    exp64 = {32'hFFFF_FFFF, 2'b01, 2'b01, 5'd2, 5'd4, 2'b10, 16'hA5C3};
    check_output("wr2_bits", last_bits_a, exp64);
    check_output("wr2_oe", last_oes_a, 64'hFFFF_FFFF_FFFF_FFFF);
    check_output("wr2_rdata_untouched", 64'(rdata_a), 64'(0));
    @(negedge clk);
    #1 check_output("cmd_done_count", 64'(done_cnt_a), 64'(4));

    $display("[TB] grant alternation under constant poll pressure");
    n = 0;
    while (nlog_b < 5 && n < 3000) begin @(negedge clk); #1; n++; end
    valid_b = 1'b0;
    check_output("alt_frames", 64'(nlog_b >= 5), 64'(1));
    check_output("alt_0_cmd", 64'(log_b[0]), 64'(1));
    check_output("alt_1_poll", 64'(log_b[1]), 64'(0));
    check_output("alt_2_cmd", 64'(log_b[2]), 64'(1));
    check_output("alt_3_poll", 64'(log_b[3]), 64'(0));
    check_output("alt_4_cmd", 64'(log_b[4]), 64'(1));

    $display("[TB] back-to-back commands with poller disabled");
    n = 0;
    while (ngap_c < 2 && n < 3000) begin @(negedge clk); #1; n++; end
    valid_c = 1'b0;
    check_output("b2b_gaps", 64'(ngap_c >= 2), 64'(1));
    check_output("b2b_gap0", 64'(gaps_c[0]), 64'(1));
    check_output("b2b_gap1", 64'(gaps_c[1]), 64'(1));
    check_output("b2b_link_never", 64'(link_seen_c), 64'(0));
    check_output("b2b_link_now", 64'(link_c), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
